// File: rtl/bus_pkg.sv
// Shared byte-bus definitions.
// bus_if and the bus endpoints both use these types.
package bus_pkg;
  localparam int BUS_DATA_W = 8;
  typedef logic [BUS_DATA_W-1:0] bus_byte_t;
endpackage

// File: rtl/bus_rx_fifo_mem.sv
// DEPTH x 8 storage for bus_rx_fifo.
// One synchronous write port, one asynchronous read port, no reset.
module bus_rx_fifo_mem
  import bus_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  bus_byte_t     wr_data,
  input  logic [AW-1:0] rd_addr,
  output bus_byte_t     rd_data
);

  bus_byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // The head entry must be visible in the same cycle for fall-through output.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bus_rx_fifo.sv
// Slave-side receiver for the valid/ready byte bus: small FIFO, FWFT output.
// Define BUS_RX_PROTO_CHECK_EN to add the sticky proto_err master-hold checker.
module bus_rx_fifo
  import bus_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  bus_byte_t     data,
  input  logic          valid,
  output logic          ready,
  output bus_byte_t     out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count
`ifdef BUS_RX_PROTO_CHECK_EN
  ,
  output logic          proto_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push;
  logic          pop;
  bus_byte_t     rd_data;

  // ready is decoded from registered occupancy only, never from valid.
  assign ready     = rst_n && (count_reg != FULL_COUNT);
  assign out_valid = (count_reg != '0);
  assign push      = valid && ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? rd_data : '0;
  assign count     = count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  bus_rx_fifo_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_reg),
    .wr_data (data),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_data)
  );

`ifdef BUS_RX_PROTO_CHECK_EN
  logic      held_reg;
  logic      proto_err_reg;
  bus_byte_t snap_reg;

  // Once the master is stalled it must keep valid high and data unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_reg      <= 1'b0;
      proto_err_reg <= 1'b0;
      snap_reg      <= '0;
    end else begin
      if (held_reg && (!valid || (data != snap_reg))) proto_err_reg <= 1'b1;
      if (push) begin
        held_reg <= 1'b0;
      end else if (valid && !held_reg) begin
        held_reg <= 1'b1;
        snap_reg <= data;
      end
    end
  end

  assign proto_err = proto_err_reg;
`endif

endmodule

// File: tb/tb_bus_rx_fifo.sv
// Directed bench for bus_rx_fifo (DEPTH=4): vector table plus hand sequences.
module tb_bus_rx_fifo;
  import bus_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  bus_byte_t  data = '0;
  logic       valid = 1'b0;
  logic       ready;
  bus_byte_t  out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] count;
`ifdef BUS_RX_PROTO_CHECK_EN
  logic       proto_err;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bus_rx_fifo #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
`ifdef BUS_RX_PROTO_CHECK_EN
    ,
    .proto_err (proto_err)
`endif
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       ordy;
    logic       exp_ready;
    logic       exp_ov;
    logic [7:0] exp_od;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic er, input logic eov,
                             input logic [7:0] eod, input logic [2:0] ecnt);
    check({tag, "_ready"}, 32'(ready), 32'(er));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(eov));
    check({tag, "_out_data"}, 32'(out_data), 32'(eod));
    check({tag, "_count"}, 32'(count), 32'(ecnt));
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic ordy);
    valid = v;
    data = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_byte_t q[$];

    // valid, data, out_ready  ->  ready, out_valid, out_data, count after the edge
    vq.push_back('{1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 8'hAA, 3'd1}); // single byte, 1-cycle latency
    vq.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0}); // pop back to empty
    vq.push_back('{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1});
    vq.push_back('{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2});
    vq.push_back('{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 3'd3});
    vq.push_back('{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4}); // full
    vq.push_back('{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4}); // 55 held, not taken
    vq.push_back('{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4});
    vq.push_back('{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h22, 3'd3}); // pop only while full
    vq.push_back('{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h33, 3'd3}); // push 55 + pop 22
    vq.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 3'd2}); // 44 from wrapped slot
    vq.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h55, 3'd1});
    vq.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0});
    vq.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0}); // no underflow
    vq.push_back('{1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 8'h77, 3'd1}); // push+pop at empty: push only
    vq.push_back('{1'b1, 8'h78, 1'b0, 1'b1, 1'b1, 8'h77, 3'd2});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_state("rst", 1'b0, 1'b0, 8'h00, 3'd0);
    rst_n = 1'b1;
    #1;
    check("rel_ready", 32'(ready), 32'd1);
`ifdef BUS_RX_PROTO_CHECK_EN
    check("rst_proto_err", 32'(proto_err), 32'd0);
`endif
    @(posedge clk);
    #1;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].v, vq[i].d, vq[i].ordy);
      check_state($sformatf("v%0d", i), vq[i].exp_ready, vq[i].exp_ov,
                  vq[i].exp_od, vq[i].exp_cnt);
      $display("vec %0d: v=%0d d=%h ordy=%0d -> ready=%0d ov=%0d od=%h cnt=%0d",
               i, vq[i].v, vq[i].d, vq[i].ordy, ready, out_valid, out_data, count);
    end

    // Streaming at count 2: one in, one out per cycle
    q.push_back(8'h77);
    q.push_back(8'h78);
    for (int i = 0; i < 20; i++) begin
      bus_byte_t b;
      b = 8'h80 + 8'(i);
      void'(q.pop_front());
      q.push_back(b);
      step(1'b1, b, 1'b1);
      check($sformatf("stream%0d_count", i), 32'(count), 32'd2);
      check($sformatf("stream%0d_out_data", i), 32'(out_data), 32'(q[0]));
      $display("stream %0d: in=%h out=%h cnt=%0d", i, b, out_data, count);
    end

    // Reset mid-stream at count 3
    step(1'b1, 8'hC0, 1'b0);
    check("pre_rst_count", 32'(count), 32'd3);
    valid = 1'b0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_state("midrst", 1'b0, 1'b0, 8'h00, 3'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("midrel_ready", 32'(ready), 32'd1);
    check("midrel_count", 32'(count), 32'd0);

    // Refill to full for the hold check
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    step(1'b1, 8'h04, 1'b0);
    check_state("refill", 1'b0, 1'b1, 8'h01, 3'd4);

`ifdef BUS_RX_PROTO_CHECK_EN
    step(1'b1, 8'h5A, 1'b0);
    check("proto_hold_ok", 32'(proto_err), 32'd0);
    step(1'b1, 8'h5A, 1'b0);
    check("proto_hold_same", 32'(proto_err), 32'd0);
    step(1'b1, 8'h5B, 1'b0);
    check("proto_changed", 32'(proto_err), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("proto_sticky", 32'(proto_err), 32'd1);
    $display("proto: err=%0d cnt=%0d", proto_err, count);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
